fetch_decode_unit: RTL and testbench
====================================

Name: fetch_decode_unit

Overview:
- Front end of the CPU pipeline: holds the program counter, fetches 16-bit instructions from instruction memory over a req/valid handshake, and decodes them.
- Its field outputs drive the *_in inputs of the decode/execute pipeline register, which samples on the falling edge of CLK.
- The execute stage sends jump redirects and stalls back into this block.

Parameters:
- PC_W, 8, program counter and instruction-memory address width
- RESET_PC, 8'h00, PC value loaded on reset

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST_N  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request, level, held until imem_valid
- imem_addr  out  PC_W  fetch address, stable while imem_req=1
- imem_rdata  in  16  instruction word, qualified by imem_valid
- imem_valid  in  1  response strobe, one cycle, ≥1 cycle after req
- stall  in  1  downstream not ready; hold current decoded instruction
- redirect  in  1  taken jump/branch from execute, single-cycle pulse
- redirect_addr  in  PC_W  jump target
- inst_valid  out  1  decoded fields below are a real instruction (else bubble/NOP)
- a_addr_out, b_addr_out, c_addr_out  out  4 each  register addresses
- immediate_val_out  out  8  immediate
- addr_out  out  8  data-memory address
- j_addr_out  out  8  jump target
- PC_out  out  PC_W  address of the presented instruction
- alu_control_out  out  3
- JCTL_out, im_ctl_out  out  2 each
- reg_write_out, data_read_out, data_write_out, reg_addr_out  out  1 each
- stack_command_out  out  1
- stack_ctl_out  out  2
- illegal_op  out  1  one-cycle pulse when opcode D–F is decoded

Behaviour:
- Reset (async, RST_N=0): PC=RESET_PC, state=FETCH, imem_req=0, inst_valid=0, all field outputs 0, illegal_op=0, flush flag=0. On the first rising edge after release, the block enters FETCH.
- FSM states:
  - FETCH: imem_req=1, imem_addr=PC → WAIT.
  - WAIT: keep req and addr. On imem_valid, latch the word, decode it, set PC_out=PC, PC=PC+1 (wraps FF→00), inst_valid=1 → HOLD.
  - HOLD: outputs stable. If stall=0, next cycle → FETCH with inst_valid=0. If stall=1, stay in HOLD, outputs unchanged.
- Fetch-to-present latency: 2 cycles plus memory latency. Outputs are registered and change only on the rising edge, so they are stable at the register's falling-edge sample.
- Redirect (any state; highest priority over stall and imem_valid):
  - PC=redirect_addr; inst_valid=0; fields cleared to NOP → FETCH.
  - If redirect arrives in WAIT, set the flush flag. The next imem_valid is discarded, and the new request is issued only after that discard, so imem_req drops for at most the pending-response window.
  - Redirect coinciding with imem_valid: the response is discarded and flush is not set.
- Decode (op = rdata[15:12]). Unlisted outputs are 0. Arithmetic op: c=[11:8], a=[7:4], b=[3:0], reg_write=1.
  - 0 NOP
  - 1 ADD alu=000; 2 SUB 001; 3 AND 010; 4 OR 011; 5 XOR 100
  - 6 LDI: c=[11:8], immediate=[7:0], im_ctl=01, reg_write=1
  - 7 LD: c=[11:8], addr=[7:0], data_read=1, reg_write=1
  - 8 ST: a=[11:8], addr=[7:0], data_write=1
  - 9 JMP: j_addr=[7:0], JCTL=01
  - A BEQ: a=[11:8], b=[7:4], j_addr={4'h0,[3:0]}, JCTL=10
  - B PUSH: a=[11:8], stack_command=1, stack_ctl=01
  - C POP: c=[11:8], stack_command=1, stack_ctl=10, reg_write=1
  - D–F: decoded as NOP with inst_valid=1 and an illegal_op pulse
- reg_addr_out is reserved and always 0.

Test Plan:
- Reset mid-WAIT, then release: imem_addr=00 and imem_req=1 on the first post-release cycle; all outputs 0 during reset.
- Zero-wait memory, imem_rdata=16'h1321 at addr 00: c=3, a=2, b=1, alu=000, reg_write=1, PC_out=00, inst_valid=1; next fetch at addr 01.
- stall=1 for 5 cycles while holding LDI 16'h6A5C: fields stay c=A, immediate=5C, im_ctl=01 throughout; no imem_req until stall drops.
- Redirect to 8'h40 in WAIT with 3-cycle memory latency: stale response ignored (inst_valid stays 0), next fetched addr=40, PC_out=40.
- PC=FF fetch: PC_out=FF, next imem_addr=00.
- Opcode E: inst_valid=1, all controls 0, illegal_op high for exactly 1 cycle.

Source files
------------

// File: rtl/fetch_decode_unit.sv
// Pipeline front end: owns the PC, fetches 16-bit words over a req/valid
// handshake and presents registered decoded fields to the decode/execute
// register. Jump redirects from execute override everything else.
module fetch_decode_unit #(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RST_N,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  input  logic            imem_valid,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_addr,
  output logic            inst_valid,
  output logic [3:0]      a_addr_out,
  output logic [3:0]      b_addr_out,
  output logic [3:0]      c_addr_out,
  output logic [7:0]      immediate_val_out,
  output logic [7:0]      addr_out,
  output logic [7:0]      j_addr_out,
  output logic [PC_W-1:0] PC_out,
  output logic [2:0]      alu_control_out,
  output logic [1:0]      JCTL_out,
  output logic [1:0]      im_ctl_out,
  output logic            reg_write_out,
  output logic            data_read_out,
  output logic            data_write_out,
  output logic            reg_addr_out,
  output logic            stack_command_out,
  output logic [1:0]      stack_ctl_out,
  output logic            illegal_op
);

  typedef enum logic [1:0] {StFetch, StWait, StHold} state_e;

  typedef struct packed {
    logic [3:0] a_addr;
    logic [3:0] b_addr;
    logic [3:0] c_addr;
    logic [7:0] imm;
    logic [7:0] addr;
    logic [7:0] j_addr;
    logic [2:0] alu;
    logic [1:0] jctl;
    logic [1:0] im_ctl;
    logic       reg_write;
    logic       data_read;
    logic       data_write;
    logic       stack_cmd;
    logic [1:0] stack_ctl;
  } fields_t;

  // Opcodes D-F fall through to an all-zero (NOP) field set.
  function automatic fields_t decode(input logic [15:0] w);
    fields_t f;
    f = '0;
    case (w[15:12])
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
        f.c_addr    = w[11:8];
        f.a_addr    = w[7:4];
        f.b_addr    = w[3:0];
        f.alu       = w[14:12] - 3'd1;  // ADD..XOR map onto 000..100
        f.reg_write = 1'b1;
      end
      4'h6: begin
        f.c_addr    = w[11:8];
        f.imm       = w[7:0];
        f.im_ctl    = 2'b01;
        f.reg_write = 1'b1;
      end
      4'h7: begin
        f.c_addr    = w[11:8];
        f.addr      = w[7:0];
        f.data_read = 1'b1;
        f.reg_write = 1'b1;
      end
      4'h8: begin
        f.a_addr     = w[11:8];
        f.addr       = w[7:0];
        f.data_write = 1'b1;
      end
      4'h9: begin
        f.j_addr = w[7:0];
        f.jctl   = 2'b01;
      end
      4'hA: begin
        f.a_addr = w[11:8];
        f.b_addr = w[7:4];
        f.j_addr = {4'h0, w[3:0]};
        f.jctl   = 2'b10;
      end
      4'hB: begin
        f.a_addr    = w[11:8];
        f.stack_cmd = 1'b1;
        f.stack_ctl = 2'b01;
      end
      4'hC: begin
        f.c_addr    = w[11:8];
        f.stack_cmd = 1'b1;
        f.stack_ctl = 2'b10;
        f.reg_write = 1'b1;
      end
      default: f = '0;
    endcase
    return f;
  endfunction

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic [PC_W-1:0] pc_out_q, pc_out_d;
  logic            req_q, req_d;
  logic            flush_q, flush_d;
  logic            valid_q, valid_d;
  logic            illegal_q, illegal_d;
  fields_t         fields_q, fields_d;

  // Next-state: redirect first, then the fetch/wait/hold sequence.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    pc_out_d  = pc_out_q;
    req_d     = req_q;
    flush_d   = flush_q;
    valid_d   = valid_q;
    fields_d  = fields_q;
    illegal_d = 1'b0;
    if (redirect) begin
      pc_d     = redirect_addr;
      valid_d  = 1'b0;
      fields_d = '0;
      req_d    = 1'b0;
      state_d  = StFetch;
      // A response still in flight must be swallowed unless it is arriving now.
      flush_d  = ((state_q == StWait) || flush_q) && !imem_valid;
    end else begin
      unique case (state_q)
        StFetch: begin
          // Hold off the new request until the stale response has been dropped.
          if (!flush_q || imem_valid) begin
            flush_d = 1'b0;
            req_d   = 1'b1;
            addr_d  = pc_q;
            state_d = StWait;
          end
        end
        StWait: begin
          if (imem_valid) begin
            fields_d  = decode(imem_rdata);
            illegal_d = (imem_rdata[15:12] >= 4'hD);
            pc_out_d  = pc_q;
            pc_d      = pc_q + PC_W'(1);
            valid_d   = 1'b1;
            req_d     = 1'b0;
            state_d   = StHold;
          end
        end
        StHold: begin
          if (!stall) begin
            valid_d = 1'b0;
            state_d = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      addr_q    <= '0;
      pc_out_q  <= '0;
      req_q     <= 1'b0;
      flush_q   <= 1'b0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      fields_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      pc_out_q  <= pc_out_d;
      req_q     <= req_d;
      flush_q   <= flush_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      fields_q  <= fields_d;
    end
  end

  assign imem_req          = req_q;
  assign imem_addr         = addr_q;
  assign inst_valid        = valid_q;
  assign PC_out            = pc_out_q;
  assign illegal_op        = illegal_q;
  assign a_addr_out        = fields_q.a_addr;
  assign b_addr_out        = fields_q.b_addr;
  assign c_addr_out        = fields_q.c_addr;
  assign immediate_val_out = fields_q.imm;
  assign addr_out          = fields_q.addr;
  assign j_addr_out        = fields_q.j_addr;
  assign alu_control_out   = fields_q.alu;
  assign JCTL_out          = fields_q.jctl;
  assign im_ctl_out        = fields_q.im_ctl;
  assign reg_write_out     = fields_q.reg_write;
  assign data_read_out     = fields_q.data_read;
  assign data_write_out    = fields_q.data_write;
  assign stack_command_out = fields_q.stack_cmd;
  assign stack_ctl_out     = fields_q.stack_ctl;
  assign reg_addr_out      = 1'b0;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit: a negedge-driven memory model with
// programmable latency answers fetches; each task checks one scenario.
module tb_fetch_decode_unit;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_addr = '0;
  logic        inst_valid;
  logic [3:0]  a_addr_out, b_addr_out, c_addr_out;
  logic [7:0]  immediate_val_out, addr_out, j_addr_out, PC_out;
  logic [2:0]  alu_control_out;
  logic [1:0]  JCTL_out, im_ctl_out, stack_ctl_out;
  logic        reg_write_out, data_read_out, data_write_out, reg_addr_out;
  logic        stack_command_out, illegal_op;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_decode_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .stall(stall), .redirect(redirect),
    .redirect_addr(redirect_addr), .inst_valid(inst_valid),
    .a_addr_out(a_addr_out), .b_addr_out(b_addr_out), .c_addr_out(c_addr_out),
    .immediate_val_out(immediate_val_out), .addr_out(addr_out), .j_addr_out(j_addr_out),
    .PC_out(PC_out), .alu_control_out(alu_control_out), .JCTL_out(JCTL_out),
    .im_ctl_out(im_ctl_out), .reg_write_out(reg_write_out), .data_read_out(data_read_out),
    .data_write_out(data_write_out), .reg_addr_out(reg_addr_out),
    .stack_command_out(stack_command_out), .stack_ctl_out(stack_ctl_out),
    .illegal_op(illegal_op)
  );

  always #5 CLK = ~CLK;

  // {a,b,c,imm,addr,jaddr,alu,jctl,imctl,rw,dr,dw,sc,sctl} plus reg_addr folded in
  logic [48:0] fields;
  assign fields = {a_addr_out, b_addr_out, c_addr_out, immediate_val_out, addr_out,
                   j_addr_out, alu_control_out, JCTL_out, im_ctl_out, reg_write_out,
                   data_read_out, data_write_out, stack_command_out | reg_addr_out,
                   stack_ctl_out};

  // Memory model: sees a request at a negedge, answers mem_lat+1 negedges later.
  logic [15:0] mem [256];
  int          mem_lat = 0;
  int          mem_cnt = 0;
  logic        mem_busy = 1'b0;
  logic [7:0]  mem_a = '0;

  always @(negedge CLK) begin
    if (!RST_N) begin
      mem_busy   = 1'b0;
      imem_valid = 1'b0;
    end else begin
      imem_valid = 1'b0;
      if (mem_busy) begin
        if (mem_cnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = mem[mem_a];
          mem_busy   = 1'b0;
        end else begin
          mem_cnt--;
        end
      end else if (imem_req === 1'b1) begin
        mem_busy = 1'b1;
        mem_cnt  = mem_lat;
        mem_a    = imem_addr;
      end
    end
  end

  task automatic apply_reset();
    @(negedge CLK);
    #2 RST_N = 1'b0;
    @(negedge CLK);
    #2 RST_N = 1'b1;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (inst_valid !== 1'b1 && cyc < 40);
  endtask

  task automatic wait_req(output int cyc);
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (imem_req !== 1'b1 && cyc < 40);
  endtask

  task automatic test_reset();
    @(negedge CLK);
    n_checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || PC_out !== 8'h00 || illegal_op !== 1'b0)
      $display("FAIL reset_ctrl: req=%b iv=%b pc=%h ill=%b want 0", imem_req, inst_valid,
               PC_out, illegal_op);
    else n_pass++;
    n_checks++;
    if (fields !== 49'h0) $display("FAIL reset_fields: got %h want 0", fields);
    else n_pass++;
    mem_lat = 6;
    #2 RST_N = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00)
      $display("FAIL release_req: req=%b addr=%h want 1/00", imem_req, imem_addr);
    else n_pass++;
    @(negedge CLK);
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || fields !== 49'h0)
      $display("FAIL mid_wait_reset: req=%b iv=%b fields=%h want 0", imem_req, inst_valid,
               fields);
    else n_pass++;
    @(negedge CLK);
    #2 RST_N = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00)
      $display("FAIL rerelease_req: req=%b addr=%h want 1/00", imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_zero_wait();
    int cyc;
    stall = 1'b0; mem_lat = 0; mem[0] = 16'h1321;
    apply_reset();
    wait_valid(cyc);
    n_checks++;
    if (inst_valid !== 1'b1 || cyc != 3)
      $display("FAIL zw_latency: iv=%b cycles=%0d want 1/3", inst_valid, cyc);
    else n_pass++;
    n_checks++;
    if (fields !== {4'h2, 4'h1, 4'h3, 8'h00, 8'h00, 8'h00, 3'b000, 2'b00, 2'b00,
                    1'b1, 1'b0, 1'b0, 1'b0, 2'b00} || PC_out !== 8'h00)
      $display("FAIL zw_add: fields=%h pc=%h", fields, PC_out);
    else n_pass++;
    wait_req(cyc);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h01 || inst_valid !== 1'b0)
      $display("FAIL zw_next: req=%b addr=%h iv=%b want 1/01/0", imem_req, imem_addr,
               inst_valid);
    else n_pass++;
  endtask

  task automatic test_stall();
    int cyc;
    mem_lat = 0; mem[0] = 16'h6A5C; stall = 1'b1;
    apply_reset();
    wait_valid(cyc);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({inst_valid, imem_req, fields} !== {1'b1, 1'b0, 4'h0, 4'h0, 4'hA, 8'h5C, 8'h00,
          8'h00, 3'b000, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00})
        $display("FAIL stall_hold[%0d]: iv=%b req=%b fields=%h", i, inst_valid, imem_req,
                 fields);
      else n_pass++;
      @(negedge CLK);
    end
    stall = 1'b0;
    wait_req(cyc);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h01 || cyc != 2)
      $display("FAIL stall_release: req=%b addr=%h cycles=%0d want 1/01/2", imem_req,
               imem_addr, cyc);
    else n_pass++;
  endtask

  task automatic test_redirect_wait();
    int cyc;
    int stale = 0;
    stall = 1'b0; mem_lat = 3; mem[0] = 16'h1111; mem[8'h40] = 16'h5432;
    apply_reset();
    @(negedge CLK);
    redirect = 1'b1; redirect_addr = 8'h40;
    @(negedge CLK);
    redirect = 1'b0;
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL rd_req_drop: req=%b want 0", imem_req);
    else n_pass++;
    cyc = 0;
    while (imem_req !== 1'b1 && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (inst_valid === 1'b1) stale++;
    end
    n_checks++;
    if (stale != 0) $display("FAIL rd_stale: inst_valid seen %0d times want 0", stale);
    else n_pass++;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h40)
      $display("FAIL rd_addr: req=%b addr=%h want 1/40", imem_req, imem_addr);
    else n_pass++;
    wait_valid(cyc);
    n_checks++;
    if (inst_valid !== 1'b1 || PC_out !== 8'h40 || fields !== {4'h3, 4'h2, 4'h4, 8'h00,
        8'h00, 8'h00, 3'b100, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00})
      $display("FAIL rd_present: iv=%b pc=%h fields=%h want 1/40", inst_valid, PC_out, fields);
    else n_pass++;
  endtask

  task automatic test_redirect_coincide();
    int cyc;
    stall = 1'b0; mem_lat = 0; mem[0] = 16'h1111; mem[8'h20] = 16'h3456;
    apply_reset();
    @(negedge CLK);
    @(negedge CLK);
    redirect = 1'b1; redirect_addr = 8'h20;
    @(negedge CLK);
    redirect = 1'b0;
    n_checks++;
    if (inst_valid !== 1'b0) $display("FAIL rc_discard: iv=%b want 0", inst_valid);
    else n_pass++;
    wait_req(cyc);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h20 || cyc != 1)
      $display("FAIL rc_refetch: req=%b addr=%h cycles=%0d want 1/20/1", imem_req, imem_addr,
               cyc);
    else n_pass++;
    wait_valid(cyc);
    n_checks++;
    if (inst_valid !== 1'b1 || PC_out !== 8'h20)
      $display("FAIL rc_present: iv=%b pc=%h want 1/20", inst_valid, PC_out);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int cyc;
    mem_lat = 0; mem[0] = 16'h1321; mem[8'hFF] = 16'h9F2A; stall = 1'b1;
    apply_reset();
    wait_valid(cyc);
    redirect = 1'b1; redirect_addr = 8'hFF;
    @(negedge CLK);
    redirect = 1'b0; stall = 1'b0;
    n_checks++;
    if (inst_valid !== 1'b0 || fields !== 49'h0)
      $display("FAIL wrap_clear: iv=%b fields=%h want 0/0", inst_valid, fields);
    else n_pass++;
    wait_req(cyc);
    n_checks++;
    if (imem_addr !== 8'hFF) $display("FAIL wrap_fetch: addr=%h want ff", imem_addr);
    else n_pass++;
    wait_valid(cyc);
    n_checks++;
    if (PC_out !== 8'hFF || fields !== {4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h2A, 3'b000,
        2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00})
      $display("FAIL wrap_present: pc=%h fields=%h want ff", PC_out, fields);
    else n_pass++;
    wait_req(cyc);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00)
      $display("FAIL wrap_next: req=%b addr=%h want 1/00", imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_illegal();
    int cyc;
    mem_lat = 0; mem[0] = 16'hE123; stall = 1'b1;
    apply_reset();
    wait_valid(cyc);
    n_checks++;
    if (inst_valid !== 1'b1 || illegal_op !== 1'b1 || fields !== 49'h0)
      $display("FAIL ill_decode: iv=%b ill=%b fields=%h want 1/1/0", inst_valid, illegal_op,
               fields);
    else n_pass++;
    @(negedge CLK);
    n_checks++;
    if (illegal_op !== 1'b0 || inst_valid !== 1'b1)
      $display("FAIL ill_pulse: ill=%b iv=%b want 0/1", illegal_op, inst_valid);
    else n_pass++;
    stall = 1'b0;
  endtask

  logic [15:0] dec_word [12];
  logic [48:0] dec_exp  [12];

  task automatic test_decode_table();
    int cyc;
    dec_word[0]  = 16'h0FFF; dec_exp[0]  = 49'h0;
    dec_word[1]  = 16'h2ABC; dec_exp[1]  = {4'hB, 4'hC, 4'hA, 8'h00, 8'h00, 8'h00, 3'b001,
                                            2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
    dec_word[2]  = 16'h3123; dec_exp[2]  = {4'h2, 4'h3, 4'h1, 8'h00, 8'h00, 8'h00, 3'b010,
                                            2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
    dec_word[3]  = 16'h4F0E; dec_exp[3]  = {4'h0, 4'hE, 4'hF, 8'h00, 8'h00, 8'h00, 3'b011,
                                            2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
    dec_word[4]  = 16'h5765; dec_exp[4]  = {4'h6, 4'h5, 4'h7, 8'h00, 8'h00, 8'h00, 3'b100,
                                            2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
    dec_word[5]  = 16'h6A5C; dec_exp[5]  = {4'h0, 4'h0, 4'hA, 8'h5C, 8'h00, 8'h00, 3'b000,
                                            2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
    dec_word[6]  = 16'h7B33; dec_exp[6]  = {4'h0, 4'h0, 4'hB, 8'h00, 8'h33, 8'h00, 3'b000,
                                            2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
    dec_word[7]  = 16'h8C81; dec_exp[7]  = {4'hC, 4'h0, 4'h0, 8'h00, 8'h81, 8'h00, 3'b000,
                                            2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
    dec_word[8]  = 16'h9F2A; dec_exp[8]  = {4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h2A, 3'b000,
                                            2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    dec_word[9]  = 16'hA3B7; dec_exp[9]  = {4'h3, 4'hB, 4'h0, 8'h00, 8'h00, 8'h07, 3'b000,
                                            2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    dec_word[10] = 16'hB500; dec_exp[10] = {4'h5, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 3'b000,
                                            2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
    dec_word[11] = 16'hC900; dec_exp[11] = {4'h0, 4'h0, 4'h9, 8'h00, 8'h00, 8'h00, 3'b000,
                                            2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10};
    stall = 1'b0; mem_lat = 1;
    for (int i = 0; i < 12; i++) begin
      mem[0] = dec_word[i];
      apply_reset();
      wait_valid(cyc);
      n_checks++;
      if (inst_valid !== 1'b1 || illegal_op !== 1'b0 || fields !== dec_exp[i])
        $display("FAIL decode_%h: iv=%b ill=%b fields=%h want %h", dec_word[i], inst_valid,
                 illegal_op, fields, dec_exp[i]);
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    #1 RST_N = 1'b0;
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_wait();
    test_redirect_coincide();
    test_wrap();
    test_illegal();
    test_decode_table();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
